// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C SCL generator.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOW       = 2'd1,
        WAIT_HIGH = 2'd2,
        HIGH      = 2'd3
    } scl_state_t;

    // Quarter-period values for 100 kHz SCL at common reference clocks.
    localparam int I2C_Q_100K_50M  = 125;
    localparam int I2C_Q_100K_100M = 250;

endpackage

// File: rtl/i2c_sync.sv
// Multi-flop synchroniser for the SCL pad readback; resets to the released level.
module i2c_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_q_nxt
);
    logic [STAGES-1:0] r_ff;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ff <= '1;
        end else begin
            r_ff <= {r_ff[STAGES-2:0], i_d};
        end
    end

    assign o_q     = r_ff[STAGES-1];
    // value o_q will hold next cycle, so registered status can line up with it
    assign o_q_nxt = r_ff[STAGES-2];

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: programmable quarter-period, clock stretching with optional
// timeout, and single-cycle phase strobes for the byte/bit engine.
//   state     | meaning
//   IDLE      | SCL released, waiting for en
//   LOW       | SCL driven low for 2Q cycles
//   WAIT_HIGH | SCL released, waiting for the pad to read high (stretch)
//   HIGH      | SCL high for 2Q cycles, then next period or stop
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH_MAX = 0
) (
    input  logic             ref_clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    input  logic             scl_in,
    output logic             scl_o,
    output logic             busy,
    output logic             tick_fall,
    output logic             tick_low_mid,
    output logic             tick_rise,
    output logic             tick_high_mid,
    output logic             stretching,
    output logic             stretch_to
);
    localparam int CW    = CNT_W + 1;
    localparam int WTO_W = (STRETCH_MAX > 0) ? $clog2(STRETCH_MAX + 1) : 1;
    localparam logic [WTO_W-1:0] WTO_LAST = (STRETCH_MAX > 0) ? WTO_W'(STRETCH_MAX - 1) : '0;

    scl_state_t       r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WTO_W-1:0] r_wcnt, w_wcnt_nxt;
    logic [CNT_W-1:0] r_q, w_q_nxt;
    logic             r_scl, w_scl_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_fall, w_fall_nxt;
    logic             r_lmid, w_lmid_nxt;
    logic             r_rise, w_rise_nxt;
    logic             r_hmid, w_hmid_nxt;
    logic             r_str, w_str_nxt;
    logic             r_sto, w_sto_nxt;

    logic             w_sync, w_sync_nxt;
    logic [CNT_W-1:0] w_div_q;
    logic [CW-1:0]    w_q_ext, w_tc, w_cnt_inc;

    i2c_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (ref_clk),
        .i_rst   (rst),
        .i_d     (scl_in),
        .o_q     (w_sync),
        .o_q_nxt (w_sync_nxt)
    );

    assign w_div_q   = (div == '0) ? CNT_W'(1) : div;
    assign w_q_ext   = {1'b0, r_q};
    assign w_tc      = {r_q, 1'b0} - CW'(1);
    assign w_cnt_inc = r_cnt + CW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wcnt_nxt  = r_wcnt;
        w_q_nxt     = r_q;
        w_scl_nxt   = r_scl;
        w_fall_nxt  = 1'b0;
        w_lmid_nxt  = 1'b0;
        w_rise_nxt  = 1'b0;
        w_hmid_nxt  = 1'b0;
        w_sto_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                w_scl_nxt = 1'b1;
                if (en) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                    w_q_nxt     = w_div_q;
                    w_scl_nxt   = 1'b0;
                    w_fall_nxt  = 1'b1;
                end
            end
            LOW: begin
                if (r_cnt == w_tc) begin
                    w_state_nxt = WAIT_HIGH;
                    w_wcnt_nxt  = '0;
                    w_scl_nxt   = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_lmid_nxt = (w_cnt_inc == w_q_ext);
                end
            end
            WAIT_HIGH: begin
                // a pad that reads high wins over a timeout in the same cycle
                if (w_sync) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                end else if ((STRETCH_MAX > 0) && (r_wcnt == WTO_LAST)) begin
                    w_state_nxt = IDLE;
                    w_sto_nxt   = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt + WTO_W'(1);
                end
            end
            HIGH: begin
                if (r_cnt == w_tc) begin
                    w_cnt_nxt = '0;
                    if (en) begin
                        w_state_nxt = LOW;
                        w_q_nxt     = w_div_q;
                        w_scl_nxt   = 1'b0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_hmid_nxt = (w_cnt_inc == w_q_ext);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
        w_str_nxt  = (w_state_nxt == WAIT_HIGH) && !w_sync_nxt;
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wcnt  <= '0;
            r_q     <= CNT_W'(1);
            r_scl   <= 1'b1;
            r_busy  <= 1'b0;
            r_fall  <= 1'b0;
            r_lmid  <= 1'b0;
            r_rise  <= 1'b0;
            r_hmid  <= 1'b0;
            r_str   <= 1'b0;
            r_sto   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_q     <= w_q_nxt;
            r_scl   <= w_scl_nxt;
            r_busy  <= w_busy_nxt;
            r_fall  <= w_fall_nxt;
            r_lmid  <= w_lmid_nxt;
            r_rise  <= w_rise_nxt;
            r_hmid  <= w_hmid_nxt;
            r_str   <= w_str_nxt;
            r_sto   <= w_sto_nxt;
        end
    end

    assign scl_o         = r_scl;
    assign busy          = r_busy;
    assign tick_fall     = r_fall;
    assign tick_low_mid  = r_lmid;
    assign tick_rise     = r_rise;
    assign tick_high_mid = r_hmid;
    assign stretching    = r_str;
    assign stretch_to    = r_sto;

endmodule
